// File: rtl/pbs_battle_dp_gen.sv
// pbs_battle_dp_gen: sequenced battle turn engine.
// Move select -> accuracy roll -> saturating damage, with a one-cycle done pulse.
module pbs_battle_dp_gen #(
  parameter int unsigned HP_W   = 4,
  parameter int unsigned MAX_HP = 15,
  parameter int unsigned MOVE_W = 2,
  parameter int unsigned ACC_W  = 4,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             actr,
  input  logic [MOVE_W-1:0]                p_move,
  input  logic                             new_battle,
  input  logic [(1 << MOVE_W)*HP_W-1:0]    dmg_tbl,
  input  logic [(1 << MOVE_W)*ACC_W-1:0]   acc_tbl,
  output logic [HP_W-1:0]                  p_hp,
  output logic [HP_W-1:0]                  ai_hp,
  output logic                             busy,
  output logic                             done,
  output logic                             hit,
  output logic [MOVE_W-1:0]                last_move,
  output logic [HP_W-1:0]                  last_dmg,
  output logic                             faint_p,
  output logic                             faint_ai
);

  localparam int unsigned NM = 1 << MOVE_W;
  localparam logic [HP_W-1:0] MAX_HP_V = HP_W'(MAX_HP);

  if (SEED == 16'h0000) begin : g_bad_seed
    $fatal(1, "pbs_battle_dp_gen: SEED must be non-zero");
  end
  if (MAX_HP < 1 || MAX_HP > (2**HP_W) - 1) begin : g_bad_max_hp
    $fatal(1, "pbs_battle_dp_gen: MAX_HP out of range");
  end
  if (MOVE_W < 1 || MOVE_W > 8 || ACC_W < 1 || ACC_W > 8) begin : g_bad_width
    $fatal(1, "pbs_battle_dp_gen: MOVE_W/ACC_W out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEL, S_ROLL, S_APPLY} state_t;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [MOVE_W-1:0] mv_q, mv_d;
  logic              att_q, att_d;
  logic              hit_q, hit_d;
  logic              done_q, done_d;
  logic [HP_W-1:0]   p_hp_q, p_hp_d;
  logic [HP_W-1:0]   ai_hp_q, ai_hp_d;
  logic [MOVE_W-1:0] last_move_q, last_move_d;
  logic [HP_W-1:0]   last_dmg_q, last_dmg_d;

  logic [HP_W-1:0]   dmg_sel;
  logic [ACC_W-1:0]  acc_sel;
  logic [HP_W-1:0]   def_hp;
  logic [HP_W-1:0]   eff_dmg;
  logic [HP_W-1:0]   dec;

  // Galois LFSR, free-running in every state
  always_comb begin
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  end

  // Per-move table lookup for the latched move
  always_comb begin
    dmg_sel = '0;
    acc_sel = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (mv_q == MOVE_W'(i)) begin
        dmg_sel = dmg_tbl[i*HP_W +: HP_W];
        acc_sel = acc_tbl[i*ACC_W +: ACC_W];
      end
    end
  end

  // Turn sequencing and saturating HP update
  always_comb begin
    state_d     = state_q;
    mv_d        = mv_q;
    att_d       = att_q;
    hit_d       = hit_q;
    done_d      = 1'b0;
    p_hp_d      = p_hp_q;
    ai_hp_d     = ai_hp_q;
    last_move_d = last_move_q;
    last_dmg_d  = last_dmg_q;
    def_hp      = att_q ? p_hp_q : ai_hp_q;
    eff_dmg     = hit_q ? dmg_sel : '0;
    dec         = (def_hp > eff_dmg) ? eff_dmg : def_hp;
    case (state_q)
      S_IDLE: begin
        if (new_battle) begin
          p_hp_d      = MAX_HP_V;
          ai_hp_d     = MAX_HP_V;
          hit_d       = 1'b0;
          last_move_d = '0;
          last_dmg_d  = '0;
        end else if (start && (p_hp_q != '0) && (ai_hp_q != '0)) begin
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        mv_d    = actr ? lfsr_q[MOVE_W-1:0] : p_move;
        att_d   = actr;
        state_d = S_ROLL;
      end
      S_ROLL: begin
        hit_d   = (lfsr_q[15 -: ACC_W] <= acc_sel);
        state_d = S_APPLY;
      end
      S_APPLY: begin
        if (att_q) p_hp_d = def_hp - dec;
        else       ai_hp_d = def_hp - dec;
        last_move_d = mv_q;
        last_dmg_d  = dec;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight turn
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED;
      mv_q        <= '0;
      att_q       <= 1'b0;
      hit_q       <= 1'b0;
      done_q      <= 1'b0;
      p_hp_q      <= MAX_HP_V;
      ai_hp_q     <= MAX_HP_V;
      last_move_q <= '0;
      last_dmg_q  <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      mv_q        <= mv_d;
      att_q       <= att_d;
      hit_q       <= hit_d;
      done_q      <= done_d;
      p_hp_q      <= p_hp_d;
      ai_hp_q     <= ai_hp_d;
      last_move_q <= last_move_d;
      last_dmg_q  <= last_dmg_d;
    end
  end

  assign p_hp      = p_hp_q;
  assign ai_hp     = ai_hp_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign hit       = hit_q;
  assign last_move = last_move_q;
  assign last_dmg  = last_dmg_q;
  assign faint_p   = (p_hp_q == '0);
  assign faint_ai  = (ai_hp_q == '0);

endmodule

// File: tb/tb_pbs_battle_dp_gen.sv
// Directed bench for pbs_battle_dp_gen: default instance plus a wide instance.
module tb_pbs_battle_dp_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Default instance (HP_W=4, MOVE_W=2, ACC_W=4)
  logic        start_a, actr_a, nb_a;
  logic [1:0]  pm_a, lmv_a;
  logic [15:0] dmg_a, acc_a;
  logic [3:0]  php_a, aihp_a, ldmg_a;
  logic        busy_a, done_a, hit_a, fp_a, fai_a;

  // Wide instance (HP_W=8, MAX_HP=200, MOVE_W=3, ACC_W=6)
  logic        start_b, actr_b, nb_b;
  logic [2:0]  pm_b, lmv_b;
  logic [63:0] dmg_b;
  logic [47:0] acc_b;
  logic [7:0]  php_b, aihp_b, ldmg_b;
  logic        busy_b, done_b, hit_b, fp_b, fai_b;

  pbs_battle_dp_gen dut_a (
    .clk(clk), .rst(rst), .start(start_a), .actr(actr_a), .p_move(pm_a),
    .new_battle(nb_a), .dmg_tbl(dmg_a), .acc_tbl(acc_a),
    .p_hp(php_a), .ai_hp(aihp_a), .busy(busy_a), .done(done_a), .hit(hit_a),
    .last_move(lmv_a), .last_dmg(ldmg_a), .faint_p(fp_a), .faint_ai(fai_a)
  );

  pbs_battle_dp_gen #(.HP_W(8), .MAX_HP(200), .MOVE_W(3), .ACC_W(6)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .actr(actr_b), .p_move(pm_b),
    .new_battle(nb_b), .dmg_tbl(dmg_b), .acc_tbl(acc_b),
    .p_hp(php_b), .ai_hp(aihp_b), .busy(busy_b), .done(done_b), .hit(hit_b),
    .last_move(lmv_b), .last_dmg(ldmg_b), .faint_p(fp_b), .faint_ai(fai_b)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference LFSR, reset and stepped independently of the DUT
  logic [15:0] m;
  function automatic logic [15:0] step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction
  always @(posedge clk or negedge rst) begin
    if (!rst) m <= 16'hACE1;
    else      m <= step(m);
  end

  logic [3:0] ea, ep;
  logic [7:0] eb_ai, eb_p;

  task automatic turn_a(input logic a, input logic [1:0] pm, output logic h_o);
    logic [15:0] ms, mr;
    logic [1:0]  mv;
    logic        h;
    logic [3:0]  d, hp, ld;
    @(negedge clk); start_a = 1'b1; actr_a = a; pm_a = pm;
    @(posedge clk); #1 ms = m;
    @(negedge clk); start_a = 1'b0;
    chk("a_busy", busy_a, 1);
    @(posedge clk); #1 mr = m;
    @(negedge clk); actr_a = ~a; pm_a = ~pm;
    mv = a ? ms[1:0] : pm;
    h  = (mr[15:12] <= acc_a[mv*4 +: 4]);
    d  = h ? dmg_a[mv*4 +: 4] : 4'd0;
    hp = a ? ep : ea;
    ld = (hp > d) ? d : hp;
    if (a) ep = hp - ld; else ea = hp - ld;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("a_done", done_a, 1);
    chk("a_hit", hit_a, h);
    chk("a_last_move", lmv_a, mv);
    chk("a_last_dmg", ldmg_a, ld);
    chk("a_p_hp", php_a, ep);
    chk("a_ai_hp", aihp_a, ea);
    chk("a_faint_p", fp_a, (ep == 0));
    chk("a_faint_ai", fai_a, (ea == 0));
    @(negedge clk);
    chk("a_done_pulse", done_a, 0);
    chk("a_busy_end", busy_a, 0);
    h_o = h;
  endtask

  task automatic turn_b(input logic a, input logic [2:0] pm);
    logic [15:0] ms, mr;
    logic [2:0]  mv;
    logic        h;
    logic [7:0]  d, hp, ld;
    @(negedge clk); start_b = 1'b1; actr_b = a; pm_b = pm;
    @(posedge clk); #1 ms = m;
    @(negedge clk); start_b = 1'b0;
    @(posedge clk); #1 mr = m;
    @(negedge clk); actr_b = ~a; pm_b = ~pm;
    mv = a ? ms[2:0] : pm;
    h  = (mr[15:10] <= acc_b[mv*6 +: 6]);
    d  = h ? dmg_b[mv*8 +: 8] : 8'd0;
    hp = a ? eb_p : eb_ai;
    ld = (hp > d) ? d : hp;
    if (a) eb_p = hp - ld; else eb_ai = hp - ld;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("b_done", done_b, 1);
    chk("b_hit", hit_b, h);
    chk("b_last_move", lmv_b, mv);
    chk("b_last_dmg", ldmg_b, ld);
    chk("b_p_hp", php_b, eb_p);
    chk("b_ai_hp", aihp_b, eb_ai);
    chk("b_faint_ai", fai_b, (eb_ai == 0));
  endtask

  task automatic nb_task_a();
    @(negedge clk); nb_a = 1'b1;
    @(negedge clk); nb_a = 1'b0;
    ea = 4'd15; ep = 4'd15;
    chk("nb_p_hp", php_a, 15);
    chk("nb_ai_hp", aihp_a, 15);
    chk("nb_hit", hit_a, 0);
    chk("nb_last_move", lmv_a, 0);
    chk("nb_last_dmg", ldmg_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic h;
    int   hits_m, hits_d, ndone, p0, p1, p2;
    start_a = 0; actr_a = 0; nb_a = 0; pm_a = 0; dmg_a = '0; acc_a = '0;
    start_b = 0; actr_b = 0; nb_b = 0; pm_b = 0; dmg_b = '0; acc_b = '0;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_p_hp", php_a, 15);
    chk("rst_ai_hp", aihp_a, 15);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_hit", hit_a, 0);
    chk("rst_last_dmg", ldmg_a, 0);
    chk("rst_faint", {fp_a, fai_a}, 0);
    chk("rst_lfsr", dut_a.lfsr_q, 16'hACE1);
    chk("rst_b_p_hp", php_b, 200);
    @(negedge clk); rst = 1'b1;
    ea = 15; ep = 15; eb_ai = 200; eb_p = 200;

    // Player move 2, damage 4, always-hit threshold
    dmg_a = 16'h3421; acc_a = 16'h0F00;
    turn_a(1'b0, 2'd2, h);
    chk("t1_ai_hp", aihp_a, 11);
    chk("t1_p_hp", php_a, 15);
    chk("t1_hit", hit_a, 1);
    chk("t1_last_dmg", ldmg_a, 4);

    // Drive AI down to 3, then overkill by 7 saturates at 0
    turn_a(1'b0, 2'd2, h);
    turn_a(1'b0, 2'd2, h);
    chk("t3_ai_hp", aihp_a, 3);
    dmg_a[11:8] = 4'd7;
    turn_a(1'b0, 2'd2, h);
    chk("sat_ai_hp", aihp_a, 0);
    chk("sat_last_dmg", ldmg_a, 3);
    chk("sat_faint_ai", fai_a, 1);

    // Start while fainted is ignored
    @(negedge clk); start_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("faint_no_busy", busy_a, 0);
      chk("faint_no_done", done_a, 0);
    end
    start_a = 1'b0;

    // Asynchronous reset mid-turn
    nb_task_a();
    @(negedge clk); start_a = 1'b1; actr_a = 0; pm_a = 2'd2;
    @(posedge clk);
    @(negedge clk); start_a = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_ai_hp", aihp_a, 15);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_lfsr", dut_a.lfsr_q, 16'hACE1);
    @(negedge clk); rst = 1'b1;
    eb_ai = 200; eb_p = 200;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_rst_no_done", done_a, 0);
      chk("mid_rst_hp_hold", aihp_a, 15);
    end

    // AI attacks with random moves, mixed thresholds
    dmg_a = 16'h3125; acc_a = 16'hF84A;
    for (int i = 0; i < 100; i++) begin
      if (ep == 0) nb_task_a();
      turn_a(1'b1, 2'(i), h);
    end

    // Threshold 0 everywhere: rare hits
    acc_a = '0; hits_m = 0; hits_d = 0;
    for (int i = 0; i < 100; i++) begin
      if (ep == 0) nb_task_a();
      turn_a(1'b1, 2'(i), h);
      hits_m += int'(h);
      hits_d += int'(hit_a);
    end
    chk("acc0_hit_count", hits_d, hits_m);
    chk("acc0_hit_rate_low", (hits_d < 30), 1);

    // start held 12 cycles; new_battle while busy ignored
    nb_task_a();
    dmg_a = 16'h0001; acc_a = 16'h000F; actr_a = 0; pm_a = 2'd0;
    ndone = 0; p0 = 0; p1 = 0; p2 = 0;
    @(negedge clk); start_a = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (done_a) begin
        ndone++;
        if (ndone == 1) p0 = c;
        if (ndone == 2) p1 = c;
        if (ndone == 3) p2 = c;
      end
      if (c == 2) nb_a = 1'b1;
      if (c == 3) nb_a = 1'b0;
      if (c == 12) start_a = 1'b0;
    end
    ea = 12;
    chk("held_done_count", ndone, 3);
    chk("held_done_pos0", p0, 4);
    chk("held_done_pos1", p1, 8);
    chk("held_done_pos2", p2, 12);
    chk("held_ai_hp", aihp_a, 12);
    chk("held_last_dmg", ldmg_a, 1);

    // start and new_battle together: new_battle wins
    @(negedge clk); start_a = 1'b1; nb_a = 1'b1;
    @(negedge clk); start_a = 1'b0; nb_a = 1'b0;
    ea = 15;
    chk("both_ai_hp", aihp_a, 15);
    chk("both_busy", busy_a, 0);
    chk("both_hit", hit_a, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("both_no_done", done_a, 0);
    end

    // Wide instance: indexing and saturation
    dmg_b = {8'd255, 8'd60, 8'd150, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    acc_b = '1;
    turn_b(1'b0, 3'd5);
    chk("b_t1_ai_hp", aihp_b, 50);
    chk("b_t1_last_dmg", ldmg_b, 150);
    turn_b(1'b0, 3'd7);
    chk("b_t2_ai_hp", aihp_b, 0);
    chk("b_t2_last_dmg", ldmg_b, 50);
    chk("b_t2_last_move", lmv_b, 7);
    @(negedge clk); nb_b = 1'b1;
    @(negedge clk); nb_b = 1'b0;
    eb_ai = 200; eb_p = 200;
    chk("b_nb_ai_hp", aihp_b, 200);
    acc_b = {6'd63, 6'd54, 6'd45, 6'd36, 6'd27, 6'd18, 6'd9, 6'd0};
    for (int i = 0; i < 8; i++) begin
      if (eb_p == 0) begin
        @(negedge clk); nb_b = 1'b1;
        @(negedge clk); nb_b = 1'b0;
        eb_ai = 200; eb_p = 200;
      end
      turn_b(1'b1, 3'(i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pbs_battle_dp_gen.md
# pbs_battle_dp_gen

Parametrised battle datapath for the Pokémon battle simulator. It replaces the fixed 4-bit, 4-move datapath with a sequenced turn engine. Each turn takes a move from the player or from the AI's pseudo-random pick, rolls accuracy against a per-move threshold, applies saturating damage to the defender's HP, and reports the result with a one-cycle `done` pulse. It sits between the battle control FSM (which drives `start`/`actr`) and the HP display logic.

## Interface
Parameters:
- `HP_W`, 4: HP and damage width in bits.
- `MAX_HP`, 15: HP loaded at reset and on `new_battle`. Must satisfy 1 ≤ MAX_HP ≤ 2^HP_W−1.
- `MOVE_W`, 2: move index width. NM = 2^MOVE_W moves. Range 1..8.
- `ACC_W`, 4: accuracy threshold and roll width. Range 1..8.
- `SEED`, 16'hACE1: LFSR reset value. Zero is illegal; elaboration must fail on zero.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `start` in 1: request one turn. Sampled only in IDLE.
- `actr` in 1: attacker select. 0 = player attacks AI; 1 = AI attacks player.
- `p_move` in MOVE_W: player's chosen move index.
- `new_battle` in 1: reload both HPs to MAX_HP. Honoured only in IDLE.
- `dmg_tbl` in NM*HP_W: damage per move. Move i occupies `[i*HP_W +: HP_W]`.
- `acc_tbl` in NM*ACC_W: accuracy threshold per move. Move i occupies `[i*ACC_W +: ACC_W]`.
- `p_hp` out HP_W: player HP.
- `ai_hp` out HP_W: AI HP.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse when a turn completes.
- `hit` out 1: last turn's move landed.
- `last_move` out MOVE_W: move used in the last turn.
- `last_dmg` out HP_W: damage actually subtracted in the last turn, after saturation.
- `faint_p` out 1: `p_hp == 0`.
- `faint_ai` out 1: `ai_hp == 0`.

## Operation
- RNG: 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Shifts right and XORs the mask when the LSB is 1. Advances every cycle in every state. Reset loads SEED.
- FSM states are IDLE → SEL → ROLL → APPLY → IDLE.
- IDLE:
  - `new_battle` = 1: both HPs are set to MAX_HP and `hit`/`last_move`/`last_dmg` are cleared. No turn starts.
  - Otherwise `start` = 1 with `faint_p` = 0 and `faint_ai` = 0 moves to SEL.
  - `start` while either side has fainted is ignored: no state change, no `done`.
- SEL: latch `mv = actr ? lfsr[MOVE_W-1:0] : p_move` and `att = actr`. `actr` and `p_move` are not sampled after this point.
- ROLL: latch `hit = (lfsr[15 -: ACC_W] <= acc_tbl[mv])`. A threshold of all-ones always hits; a threshold of 0 hits with probability 1/2^ACC_W.
- APPLY:
  - Defender is AI when `att` = 0, player when `att` = 1.
  - d = hit ? dmg_tbl[mv] : 0.
  - Defender HP becomes `hp > d ? hp − d : 0`. HP never wraps and never increases.
  - `last_dmg` = the actual HP decrease, `min(d, hp)`. `last_move` = mv.
  - `done` is asserted and the FSM returns to IDLE.
- `faint_*` are combinational from the HP registers.

## Timing
- Reset values: state IDLE; `p_hp` = `ai_hp` = MAX_HP; `busy`, `done`, `hit`, `last_move`, `last_dmg` = 0; `faint_*` = 0; lfsr = SEED. Reset takes effect immediately and asynchronously, including mid-turn. An in-flight turn is abandoned with no `done` and no HP change.
- For `start` sampled at edge k:
  - `busy` rises after edge k.
  - `mv` is latched at edge k+1.
  - `hit` is latched at edge k+2.
  - HP, `last_*` and `done` are updated at edge k+3.
  - `busy` falls after edge k+3.
  - Turn latency is 3 cycles.
- `done` is high for exactly one cycle. `start` held high gives back-to-back turns: the next turn's edge k' = k+4.
- `start` and `new_battle` while busy are ignored; they are not queued.
- `start` and `new_battle` high together in IDLE: `new_battle` wins and `start` is dropped.
- `hit` and `last_*` hold their values until the next APPLY or `new_battle`.

## Test plan
- Reset with HP_W=4, MAX_HP=15 → `p_hp` = `ai_hp` = 15, `busy` = 0, `done` = 0, lfsr = 16'hACE1. Assert `rst` = 0 mid-turn → same values and no `done`.
- `actr` = 0, `p_move` = 2, `dmg_tbl[2]` = 4, `acc_tbl[2]` = 15, start pulse → `done` 3 cycles later, `ai_hp` = 11, `p_hp` = 15, `hit` = 1, `last_dmg` = 4.
- `ai_hp` = 3, move damage 7, always-hit threshold → `ai_hp` = 0, `last_dmg` = 3, `faint_ai` = 1. A following start → no `busy`, no `done`.
- `actr` = 1 with a reference LFSR model over 200 turns → `last_move`, `hit` and `p_hp` match the model on every turn. With `acc_tbl` all 0, the hit rate is ≈1/16.
- `start` held high for 12 cycles → exactly 3 `done` pulses, 4 cycles apart. `new_battle` asserted while busy → ignored.
- `start` and `new_battle` together in IDLE → HPs = MAX_HP, no turn. Sweep HP_W=8, MAX_HP=200, MOVE_W=3, ACC_W=6 → table indexing and saturation are correct.
